// File: rtl/mux_pinmux_in.sv
// Pad-group input mux: synchronises and glitch-filters the pad bus, then routes it
// to the selected peripheral input ports with registered rise/fall pulses.
module mux_pinmux_in #(
  parameter int unsigned NUM_PERIPHERALS = 4,
  parameter int unsigned DATA_WIDTH      = 1,
  parameter int unsigned SEL_WIDTH       = 5,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned FILTER_CNT      = 3,
  parameter logic        IDLE_VAL        = 1'b0
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [SEL_WIDTH-1:0]                  i_sel,
  input  logic [DATA_WIDTH-1:0]                 i_pad_in,
  output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] o_periph_in,
  output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] o_rise,
  output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] o_fall
);

  localparam int unsigned PW    = NUM_PERIPHERALS * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(FILTER_CNT + 1);

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(FILTER_CNT - 1);
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {DATA_WIDTH{IDLE_VAL}};
  localparam logic [PW-1:0]         IDLE_BUS  = {PW{IDLE_VAL}};

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0]                  sync_out;
  logic [DATA_WIDTH-1:0]                  filt_q;
  logic [DATA_WIDTH-1:0][CNT_W-1:0]       cnt_q;
  logic [SEL_WIDTH-1:0]                   sel_q;
  logic [SEL_WIDTH-1:0]                   sel_d;
  logic [NUM_PERIPHERALS-1:0]             en_c;
  logic [NUM_PERIPHERALS-1:0]             sw_c;
  logic [PW-1:0]                          next_c;
  logic [PW-1:0]                          hold_c;
  logic                                   sel_unused;

  // Pad synchroniser: stage 0 samples the asynchronous pad
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_WORD}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pad_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Per-bit stability filter; any return to the held value restarts the count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_q <= IDLE_WORD;
      cnt_q  <= '0;
    end else begin
      for (int b = 0; b < int'(DATA_WIDTH); b++) begin
        if (sync_out[b] == filt_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == CNT_LAST) begin
          filt_q[b] <= sync_out[b];
          cnt_q[b]  <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  // sel_d trails sel_q by one cycle so a routing switch can be detected
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_q <= '0;
      sel_d <= '0;
    end else begin
      sel_q <= i_sel;
      sel_d <= sel_q;
    end
  end

  // Select bits beyond the peripheral count are deliberately ignored
  assign sel_unused = ^{sel_q, sel_d};

  for (genvar g = 0; g < int'(NUM_PERIPHERALS); g++) begin : g_sel
    if (g < int'(SEL_WIDTH)) begin : g_on
      assign en_c[g] = sel_q[g];
      assign sw_c[g] = sel_q[g] ^ sel_d[g];
    end else begin : g_off
      assign en_c[g] = 1'b0;
      assign sw_c[g] = 1'b0;
    end
  end

  always_comb begin
    next_c = IDLE_BUS;
    hold_c = '0;
    for (int g = 0; g < int'(NUM_PERIPHERALS); g++) begin
      if (en_c[g]) next_c[g*DATA_WIDTH +: DATA_WIDTH] = filt_q;
      if (sw_c[g]) hold_c[g*DATA_WIDTH +: DATA_WIDTH] = '1;
    end
  end

  // Routed data and edge pulses; switching slices never report an edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_periph_in <= IDLE_BUS;
      o_rise      <= '0;
      o_fall      <= '0;
    end else begin
      o_periph_in <= next_c;
      o_rise      <= ~o_periph_in &  next_c & ~hold_c;
      o_fall      <=  o_periph_in & ~next_c & ~hold_c;
    end
  end

endmodule

// File: doc/mux_pinmux_in.md
Name: mux_pinmux_in

Overview:
- Input-direction counterpart of the pinmux output mux.
- Takes the pad input bus, synchronises it into the core clock domain and glitch-filters it.
- Routes the filtered value to the peripheral(s) whose select bit is set. Unselected peripherals see a fixed idle level.
- Emits registered per-peripheral rise/fall pulses. Sits between the pad ring and the peripheral input ports, one instance per pad group.

Parameters:
- NUM_PERIPHERALS, 4, number of peripheral input ports served.
- DATA_WIDTH, 1, pad bits per peripheral slot.
- SEL_WIDTH, 5, width of the per-peripheral select vector; bit g selects peripheral g.
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- FILTER_CNT, 3, consecutive stable cycles required before the filtered value changes; legal range 1..15.
- IDLE_VAL, 0, 1-bit level driven on every bit of unselected peripherals and used as reset value.

Ports:
- i_clk  input  1  core clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_sel  input  SEL_WIDTH  peripheral select; bit g routes the pad to peripheral g.
- i_pad_in  input  DATA_WIDTH  raw pad input, asynchronous to i_clk.
- o_periph_in  output  NUM_PERIPHERALS*DATA_WIDTH  routed data; slice g = [(g+1)*DATA_WIDTH-1 : g*DATA_WIDTH].
- o_rise  output  NUM_PERIPHERALS*DATA_WIDTH  one-cycle pulse per bit on 0->1 of routed data.
- o_fall  output  NUM_PERIPHERALS*DATA_WIDTH  one-cycle pulse per bit on 1->0 of routed data.

Behaviour:
- Reset is asynchronous and active-low.
  - Every synchroniser flop, the filter value and o_periph_in reset to IDLE_VAL.
  - Filter counters, sel_q, o_rise and o_fall reset to 0.
  - Release of reset is synchronous to i_clk.
- Synchroniser:
  - Per-bit chain of SYNC_STAGES flops, no reset-value bypass.
  - sync_out equals i_pad_in sampled SYNC_STAGES edges earlier.
- Filter, per bit, independent:
  - Counter cnt has width ceil(log2(FILTER_CNT+1)).
  - If sync_out == filt: cnt <= 0.
  - Else if cnt == FILTER_CNT-1: filt <= sync_out and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return to equality before the threshold clears cnt. A pulse shorter than FILTER_CNT cycles never reaches filt.
  - FILTER_CNT=1 means filt follows sync_out with one register.
- Select:
  - i_sel is registered into sel_q every cycle with no filtering.
  - Peripheral g (g < min(NUM_PERIPHERALS, SEL_WIDTH)) is selected when sel_q[g]=1.
  - Peripherals with index >= SEL_WIDTH are never selected. Select bits with index >= NUM_PERIPHERALS are ignored.
  - Multiple set bits broadcast filt to every selected peripheral. No select bit set means all slices are idle.
- Output register:
  - o_periph_in slice g <= sel_q[g] ? filt : {DATA_WIDTH{IDLE_VAL}}.
- Latency:
  - From a pad change stable before edge k to the o_periph_in change: SYNC_STAGES + FILTER_CNT + 1 edges.
  - With defaults, 6 edges.
  - From an i_sel change to the o_periph_in change: 2 edges.
- Edge pulses:
  - o_rise[b] <= ~o_periph_in[b] & next[b]; o_fall[b] <= o_periph_in[b] & ~next[b], where next is the value being loaded into o_periph_in. Both are registered together with o_periph_in.
  - Suppression: for any slice whose sel_q bit changed in the same cycle, both pulses are forced to 0. Routing switches never produce edge events.
- Simultaneous events: a filter update and a select change in the same cycle → the new filt value is routed and no pulse is generated for the switching slice. Other slices pulse normally.
- Reset mid-operation: all state returns to reset values immediately. Filter counting restarts from 0 after release.

Test Plan:
- Reset with i_pad_in=1, i_sel=5'b00001 → during reset all outputs are 0. After release, o_periph_in[0] rises on edge 6 with o_rise[0]=1 for exactly one cycle; other slices stay 0.
- i_sel=00010, pad pulses high for 2 cycles then low → o_periph_in stays 0, no o_rise/o_fall (filter rejects).
- i_sel=00010, pad 0->1 held 10 cycles → o_periph_in[1]=1 exactly 6 edges after the change, o_rise[1] pulses once. Pad back to 0 → o_fall[1] 6 edges later.
- Pad stable 1, i_sel switches 00001→00100 → slice 0 drops to 0 and slice 2 goes to 1, both 2 edges after the switch. No o_rise/o_fall on any slice.
- i_sel=00101 (broadcast) with pad toggling slowly → slices 0 and 2 are identical with simultaneous pulses. i_sel=10000 → all slices idle (bit 4 exceeds NUM_PERIPHERALS).
- Assert i_rst_n low mid-filter (cnt=2) → outputs 0 immediately. After release with pad still changed, full 6-edge latency applies again.
